// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped LED/channel controller:
// channel modes, register offsets and register field positions.
package mmio_pkg;

   // Channel output modes (CHn[1:0])
   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_ON    = 2'd1;
   localparam logic [1:0] MODE_PWM   = 2'd2;
   localparam logic [1:0] MODE_BLINK = 2'd3;

   // Register word offsets; STATUS sits directly after the last channel
   localparam int unsigned ADDR_CTRL = 0;
   localparam int unsigned ADDR_CH0  = 1;

   // CTRL fields
   localparam int unsigned CTRL_EN_BIT    = 0;
   localparam int unsigned CTRL_PRESC_LSB = 8;
   localparam int unsigned CTRL_PRESC_W   = 16;

   // CHn fields
   localparam int unsigned CH_MODE_LSB = 0;
   localparam int unsigned CH_MODE_W   = 2;
   localparam int unsigned CH_DUTY_LSB = 2;

endpackage

// File: rtl/pwm_timebase.sv
// Shared timebase: prescaler, free-running PWM counter and blink phase.
// Everything is held at zero while the controller is disabled.
module pwm_timebase
   import mmio_pkg::*;
#(
   parameter int unsigned PWM_BITS = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [CTRL_PRESC_W-1:0] presc,
   input  logic                    presc_wr,
   output logic [PWM_BITS-1:0]     pwm_cnt,
   output logic                    blink_ph,
   output logic                    tick
);

   localparam logic [PWM_BITS-1:0] PwmMax = '1;

   logic [CTRL_PRESC_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [PWM_BITS-1:0]     pwm_cnt_q, pwm_cnt_d;
   logic                    blink_q, blink_d;

   // Next-state: tick uses the current prescaler value, so a CTRL write on a tick
   // edge still advances the counters and the new PRESC applies from the next cycle.
   always_comb begin
      tick      = en && (pre_cnt_q == presc);
      pre_cnt_d = pre_cnt_q + CTRL_PRESC_W'(1);
      pwm_cnt_d = pwm_cnt_q;
      blink_d   = blink_q;
      if (tick || presc_wr) begin
         pre_cnt_d = '0;
      end
      if (tick) begin
         pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
         if (pwm_cnt_q == PwmMax) begin
            blink_d = ~blink_q;
         end
      end
      if (!en) begin
         pre_cnt_d = '0;
         pwm_cnt_d = '0;
         blink_d   = 1'b0;
      end
   end

   // Counter state with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt_q <= '0;
         pwm_cnt_q <= '0;
         blink_q   <= 1'b0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
         pwm_cnt_q <= pwm_cnt_d;
         blink_q   <= blink_d;
      end
   end

   assign pwm_cnt  = pwm_cnt_q;
   assign blink_ph = blink_q;

endmodule

// File: rtl/mmio_led_ctrl.sv
// Memory-mapped channel controller: register file, address decode, single-cycle
// response register and per-channel OFF/ON/PWM/BLINK output stage.
module mmio_led_ctrl
   import mmio_pkg::*;
#(
   parameter int unsigned NUM_CH    = 8,
   parameter int unsigned BUS_WIDTH = 32,
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned PWM_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   input  logic                 req_we,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [BUS_WIDTH-1:0] req_wdata,
   output logic                 rsp_valid,
   output logic                 rsp_err,
   output logic [BUS_WIDTH-1:0] rsp_rdata,
   output logic [NUM_CH-1:0]    io_out
);

   localparam logic [ADDR_W-1:0] AddrCtrl   = ADDR_W'(ADDR_CTRL);
   localparam logic [ADDR_W-1:0] AddrStatus = ADDR_W'(ADDR_CH0 + NUM_CH);

   // Register file
   logic                                 ctrl_en_q;
   logic [CTRL_PRESC_W-1:0]              ctrl_presc_q;
   logic [NUM_CH-1:0][CH_MODE_W-1:0]     ch_mode_q;
   logic [NUM_CH-1:0][PWM_BITS-1:0]      ch_duty_q;

   // Decode
   logic                 hit_ctrl, hit_status, req_err, wr_ok, ctrl_wr;
   logic [NUM_CH-1:0]    hit_ch, ch_wr;
   logic [BUS_WIDTH-1:0] rdata_d;

   // Response and output registers
   logic                 rsp_valid_q, rsp_err_q;
   logic [BUS_WIDTH-1:0] rsp_rdata_q;
   logic [NUM_CH-1:0]    io_d, io_q;

   // Timebase
   logic [PWM_BITS-1:0]  pwm_cnt;
   logic                 blink_ph;
   logic                 unused_tick;
   logic                 unused_wdata;

   // Only some write-data bits map to register fields; the rest are ignored.
   assign unused_wdata = ^req_wdata;

   pwm_timebase #(
      .PWM_BITS (PWM_BITS)
   ) u_timebase (
      .clk      (clk),
      .rst      (rst),
      .en       (ctrl_en_q),
      .presc    (ctrl_presc_q),
      .presc_wr (ctrl_wr),
      .pwm_cnt  (pwm_cnt),
      .blink_ph (blink_ph),
      .tick     (unused_tick)
   );

   // Address decode, error detection and read-data mux from current register values
   always_comb begin
      hit_ctrl   = (req_addr == AddrCtrl);
      hit_status = (req_addr == AddrStatus);
      hit_ch     = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         hit_ch[n] = (req_addr == ADDR_W'(ADDR_CH0 + n));
      end
      req_err = !(hit_ctrl || hit_status || (|hit_ch)) || (req_we && hit_status);
      wr_ok   = req_valid && req_we && !req_err;
      ctrl_wr = wr_ok && hit_ctrl;
      ch_wr   = {NUM_CH{wr_ok}} & hit_ch;

      rdata_d = '0;
      if (req_valid && !req_we && !req_err) begin
         if (hit_ctrl) begin
            rdata_d[CTRL_EN_BIT]                   = ctrl_en_q;
            rdata_d[CTRL_PRESC_LSB +: CTRL_PRESC_W] = ctrl_presc_q;
         end
         if (hit_status) begin
            rdata_d[PWM_BITS-1:0] = pwm_cnt;
            rdata_d[PWM_BITS]     = blink_ph;
         end
         for (int n = 0; n < NUM_CH; n++) begin
            if (hit_ch[n]) begin
               rdata_d[CH_MODE_LSB +: CH_MODE_W] = ch_mode_q[n];
               rdata_d[CH_DUTY_LSB +: PWM_BITS]  = ch_duty_q[n];
            end
         end
      end
   end

   // Register file writes; erroneous requests leave all state untouched
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_en_q    <= 1'b0;
         ctrl_presc_q <= '0;
         ch_mode_q    <= '0;
         ch_duty_q    <= '0;
      end else begin
         if (ctrl_wr) begin
            ctrl_en_q    <= req_wdata[CTRL_EN_BIT];
            ctrl_presc_q <= req_wdata[CTRL_PRESC_LSB +: CTRL_PRESC_W];
         end
         for (int n = 0; n < NUM_CH; n++) begin
            if (ch_wr[n]) begin
               ch_mode_q[n] <= req_wdata[CH_MODE_LSB +: CH_MODE_W];
               ch_duty_q[n] <= req_wdata[CH_DUTY_LSB +: PWM_BITS];
            end
         end
      end
   end

   // Response register: every request answers exactly one cycle later
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= req_valid;
         rsp_err_q   <= req_valid && req_err;
         rsp_rdata_q <= rdata_d;
      end
   end

   // Per-channel output select; disabled controller forces every channel low
   always_comb begin
      io_d = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         unique case (ch_mode_q[n])
            MODE_OFF:   io_d[n] = 1'b0;
            MODE_ON:    io_d[n] = 1'b1;
            MODE_PWM:   io_d[n] = (pwm_cnt < ch_duty_q[n]);
            MODE_BLINK: io_d[n] = blink_ph;
            default:    io_d[n] = 1'b0;
         endcase
      end
      if (!ctrl_en_q) begin
         io_d = '0;
      end
   end

   // Registered channel outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         io_q <= '0;
      end else begin
         io_q <= io_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign io_out    = io_q;

endmodule

// File: tb/tb_mmio_led_ctrl.sv
// Directed bench for mmio_led_ctrl with default parameters (8 channels, 8-bit PWM).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mmio_led_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [5:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_err;
   logic [31:0] rsp_rdata;
   logic [7:0]  io_out;

   int n_checks;
   int n_fail;

   logic        r_valid;
   logic        r_err;
   logic [31:0] r_data;

   mmio_led_ctrl #(
      .NUM_CH    (8),
      .BUS_WIDTH (32),
      .ADDR_W    (6),
      .PWM_BITS  (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_err   (rsp_err),
      .rsp_rdata (rsp_rdata),
      .io_out    (io_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One request; called at a falling edge, returns at the next falling edge with the response.
   task automatic do_req(input logic we, input logic [5:0] addr, input logic [31:0] wdata);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0;
      req_we    = 1'b0;
      r_valid   = rsp_valid;
      r_err     = rsp_err;
      r_data    = rsp_rdata;
   endtask

   task automatic wr_ok(input string tag, input logic [5:0] addr, input logic [31:0] wdata);
      do_req(1'b1, addr, wdata);
      check({tag, "_valid"}, 32'(r_valid), 32'd1);
      check({tag, "_err"}, 32'(r_err), 32'd0);
      check({tag, "_rdata"}, r_data, 32'd0);
   endtask

   task automatic rd_chk(input string tag, input logic [5:0] addr, input logic [31:0] exp);
      do_req(1'b0, addr, 32'd0);
      check({tag, "_valid"}, 32'(r_valid), 32'd1);
      check({tag, "_err"}, 32'(r_err), 32'd0);
      check({tag, "_rdata"}, r_data, exp);
   endtask

   task automatic err_chk(input string tag, input logic we, input logic [5:0] addr,
                          input logic [31:0] wdata);
      do_req(we, addr, wdata);
      check({tag, "_valid"}, 32'(r_valid), 32'd1);
      check({tag, "_err"}, 32'(r_err), 32'd1);
      check({tag, "_rdata"}, r_data, 32'd0);
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Count cycles over a 256-cycle window where io_out[ch] equals level.
   task automatic count_level(input int ch, input logic level, output int cnt);
      cnt = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (io_out[ch] == level) cnt++;
      end
   endtask

   initial begin
      int cnt;
      int n_tog;
      int tog_at [4];
      logic prev;

      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      wait_cycles(3);
      rst = 1'b0;

      // Reset state
      check("rst_io", 32'(io_out), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      rd_chk("rst_status", 6'd9, 32'd0);
      rd_chk("rst_ch1", 6'd1, 32'd0);

      // Enable with PRESC=0: pwm_cnt advances from the first edge after the write
      wr_ok("ctrl_en", 6'd0, 32'h0000_0001);
      rd_chk("status_0", 6'd9, 32'd0);
      rd_chk("status_1", 6'd9, 32'd1);

      // PWM duty 64 on channel 0
      wr_ok("ch1_pwm64", 6'd1, 32'h0000_0102);
      rd_chk("ch1_rb", 6'd1, 32'h0000_0102);
      wait_cycles(4);
      count_level(0, 1'b1, cnt);
      check("pwm64_high", 32'(cnt), 32'd64);

      // Mid-operation reset for two cycles; the coincident request is dropped
      rst       = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 6'd0;
      @(negedge clk);
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_io", 32'(io_out), 32'd0);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("postrst_io", 32'(io_out), 32'd0);
      rd_chk("postrst_status", 6'd9, 32'd0);
      rd_chk("postrst_ctrl", 6'd0, 32'd0);
      rd_chk("postrst_ch1", 6'd1, 32'd0);

      // Blink on channel 1 with PRESC=3: toggles every 4*256 cycles
      wr_ok("ctrl_presc3", 6'd0, 32'h0000_0301);
      wr_ok("ch2_blink", 6'd2, 32'h0000_0003);
      n_tog = 0;
      prev  = io_out[1];
      for (int i = 0; i < 3300; i++) begin
         @(negedge clk);
         if (io_out[1] != prev) begin
            if (n_tog < 4) tog_at[n_tog] = i;
            n_tog++;
         end
         prev = io_out[1];
      end
      check("blink_enough_toggles", 32'(n_tog >= 3), 32'd1);
      check("blink_period_a", 32'(tog_at[1] - tog_at[0]), 32'd1024);
      check("blink_period_b", 32'(tog_at[2] - tog_at[1]), 32'd1024);

      // ON channel, then disable: output drops one cycle after the CTRL response
      wr_ok("ch3_on", 6'd3, 32'h0000_0001);
      wait_cycles(2);
      check("ch3_on_io", 32'(io_out[2]), 32'd1);
      wr_ok("ctrl_dis", 6'd0, 32'h0000_0300);
      check("dis_rsp_cycle_io", 32'(io_out[2]), 32'd1);
      @(negedge clk);
      check("dis_next_io", 32'(io_out), 32'd0);
      rd_chk("dis_status", 6'd9, 32'd0);
      rd_chk("dis_ctrl", 6'd0, 32'h0000_0300);

      // Bad address and read-only writes change nothing
      err_chk("bad_rd", 1'b0, 6'd10, 32'd0);
      err_chk("status_wr", 1'b1, 6'd9, 32'hFFFF_FFFF);
      err_chk("bad_wr", 1'b1, 6'd63, 32'h0000_0001);
      rd_chk("err_ctrl", 6'd0, 32'h0000_0300);
      rd_chk("err_status", 6'd9, 32'd0);
      rd_chk("err_ch1", 6'd1, 32'd0);
      rd_chk("err_ch3", 6'd3, 32'h0000_0001);
      check("err_io", 32'(io_out), 32'd0);

      // Duty bounds with PRESC=0
      wr_ok("ctrl_presc0", 6'd0, 32'h0000_0001);
      wr_ok("ch1_duty0", 6'd1, 32'h0000_0002);
      wait_cycles(4);
      count_level(0, 1'b1, cnt);
      check("duty0_high", 32'(cnt), 32'd0);
      wr_ok("ch1_duty255", 6'd1, 32'h0000_03FE);
      wait_cycles(4);
      count_level(0, 1'b0, cnt);
      check("duty255_low", 32'(cnt), 32'd1);

      // Back-to-back write then read of CH1
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 6'd1;
      req_wdata = 32'h0000_00FE;
      @(negedge clk);
      check("b2b_wr_valid", 32'(rsp_valid), 32'd1);
      check("b2b_wr_err", 32'(rsp_err), 32'd0);
      check("b2b_wr_rdata", rsp_rdata, 32'd0);
      req_we = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      check("b2b_rd_valid", 32'(rsp_valid), 32'd1);
      check("b2b_rd_rdata", rsp_rdata, 32'h0000_00FE);
      @(negedge clk);
      check("b2b_idle_valid", 32'(rsp_valid), 32'd0);

      // Unused bits read back as zero
      wr_ok("ch1_all1", 6'd1, 32'hFFFF_FFFF);
      rd_chk("ch1_all1_rb", 6'd1, 32'h0000_03FF);
      wr_ok("ctrl_all1", 6'd0, 32'hFFFF_FFFF);
      rd_chk("ctrl_all1_rb", 6'd0, 32'h00FF_FF01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
